// File: rtl/char_lexer_pkg.sv
// Shared widths, token encodings, state/status enums and the symbol hash step
// for the streaming lexer.
package char_lexer_pkg;

  localparam int TYPE_WIDTH  = 5;
  localparam int VALUE_WIDTH = 16;
  localparam int CHAR_WIDTH  = 9;

  localparam logic [CHAR_WIDTH-1:0] CHAR_EOF = 9'h1ff;

  localparam logic [TYPE_WIDTH-1:0] TOK_NONE   = 5'd0;
  localparam logic [TYPE_WIDTH-1:0] TOK_LPAREN = 5'd1;
  localparam logic [TYPE_WIDTH-1:0] TOK_RPAREN = 5'd2;
  localparam logic [TYPE_WIDTH-1:0] TOK_LAMBDA = 5'd3;
  localparam logic [TYPE_WIDTH-1:0] TOK_DOT    = 5'd4;
  localparam logic [TYPE_WIDTH-1:0] TOK_NUM    = 5'd5;
  localparam logic [TYPE_WIDTH-1:0] TOK_SYM    = 5'd6;
  localparam logic [TYPE_WIDTH-1:0] TOK_EOF    = 5'd7;

  typedef enum logic [2:0] {SKIP, NUM, SYM, DONE, ERROR} lex_state_t;

  typedef enum logic [2:0] {
    status_ok  = 3'd0,
    status_err = 3'd1,
    status_eof = 3'd2
  } status_t;

  typedef enum logic [2:0] {
    CC_WS, CC_PUNCT, CC_DIGIT, CC_ALPHA, CC_EOF, CC_ILLEGAL
  } char_class_t;

  // acc*31 + c, wrapping at 16 bits
  function automatic logic [VALUE_WIDTH-1:0] sym_step(input logic [VALUE_WIDTH-1:0] acc,
                                                      input logic [7:0] c);
    return (acc << 5) - acc + {8'd0, c};
  endfunction

endpackage

// File: rtl/char_lexer_if.sv
// Character-in / token-out handshake bundle between the file reader, the lexer
// and the term builder.
interface char_lexer_if;
  import char_lexer_pkg::*;

  logic [CHAR_WIDTH-1:0]  in_char;
  logic                   in_valid;
  logic                   in_ready;
  logic [TYPE_WIDTH-1:0]  tok_type;
  logic [VALUE_WIDTH-1:0] tok_value;
  logic                   tok_valid;
  logic                   tok_ready;
  status_t                status;

  modport master (
    output in_char, in_valid, tok_ready,
    input  in_ready, tok_type, tok_value, tok_valid, status
  );

  modport slave (
    input  in_char, in_valid, tok_ready,
    output in_ready, tok_type, tok_value, tok_valid, status
  );

endinterface

// File: rtl/char_lexer_class.sv
// Combinational character classifier: class, punctuation token type and
// decimal digit value of one char_t.
module char_class
  import char_lexer_pkg::*;
(
  input  logic [CHAR_WIDTH-1:0] ch,
  output char_class_t           cls,
  output logic [TYPE_WIDTH-1:0] punct_tok,
  output logic [3:0]            digit
);

  always_comb begin
    cls       = CC_ILLEGAL;
    punct_tok = TOK_NONE;
    digit     = 4'd0;
    if (ch == CHAR_EOF) begin
      cls = CC_EOF;
    end else if (!ch[8]) begin
      case (ch[7:0])
        8'h20, 8'h09, 8'h0a, 8'h0d: cls = CC_WS;
        8'h28: begin cls = CC_PUNCT; punct_tok = TOK_LPAREN; end
        8'h29: begin cls = CC_PUNCT; punct_tok = TOK_RPAREN; end
        8'h5c: begin cls = CC_PUNCT; punct_tok = TOK_LAMBDA; end
        8'h2e: begin cls = CC_PUNCT; punct_tok = TOK_DOT;    end
        default: begin
          // '0'..'9' sit at 0x30..0x39, so the low nibble is the digit value
          if (ch[7:0] >= 8'h30 && ch[7:0] <= 8'h39) begin
            cls   = CC_DIGIT;
            digit = ch[3:0];
          end else if ((ch[7:0] >= 8'h61 && ch[7:0] <= 8'h7a) ||
                       (ch[7:0] >= 8'h41 && ch[7:0] <= 8'h5a) ||
                       (ch[7:0] == 8'h5f)) begin
            cls = CC_ALPHA;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/char_lexer.sv
// Streaming lexer: turns the char_t stream into typed tokens, accumulating
// numbers and symbol hashes, with a one-entry pending slot for delimiters.
module char_lexer
  import char_lexer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  char_lexer_if.slave bus
);

  lex_state_t             state, state_n;
  logic [VALUE_WIDTH-1:0] acc, acc_n;
  logic                   tok_valid;
  logic [TYPE_WIDTH-1:0]  tok_type;
  logic [VALUE_WIDTH-1:0] tok_value;
  logic                   pend_valid;
  logic [TYPE_WIDTH-1:0]  pend_type;

  char_class_t           cls;
  logic [TYPE_WIDTH-1:0] punct_tok;
  logic [3:0]            digit;

  logic                   accept, out_free, in_ready;
  logic                   emit, pend_load;
  logic [TYPE_WIDTH-1:0]  emit_type, pend_type_n;
  logic [VALUE_WIDTH-1:0] emit_value;
  logic [19:0]            num_next;

  char_class u_class (
    .ch        (bus.in_char),
    .cls       (cls),
    .punct_tok (punct_tok),
    .digit     (digit)
  );

  assign out_free = ~tok_valid | bus.tok_ready;
  assign in_ready = ~rst & ((state == SKIP) | (state == NUM) | (state == SYM)) &
                    ~pend_valid & out_free;
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.tok_valid = tok_valid;
  assign bus.tok_type  = tok_type;
  assign bus.tok_value = tok_value;

  always_comb begin
    case (state)
      ERROR:   bus.status = status_err;
      DONE:    bus.status = status_eof;
      default: bus.status = status_ok;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SKIP;
      acc   <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
    end
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    emit        = 1'b0;
    emit_type   = TOK_NONE;
    emit_value  = '0;
    pend_load   = 1'b0;
    pend_type_n = TOK_NONE;
    num_next    = {4'd0, acc} * 20'd10 + {16'd0, digit};
    if (accept) begin
      case (state)
        SKIP: begin
          case (cls)
            CC_PUNCT: begin emit = 1'b1; emit_type = punct_tok; end
            CC_DIGIT: begin acc_n = {12'd0, digit}; state_n = NUM; end
            CC_ALPHA: begin acc_n = {8'd0, bus.in_char[7:0]}; state_n = SYM; end
            CC_EOF:   begin emit = 1'b1; emit_type = TOK_EOF; state_n = DONE; end
            CC_ILLEGAL: state_n = ERROR;
            default: ;
          endcase
        end
        NUM, SYM: begin
          if (cls == CC_ILLEGAL || (state == NUM && cls == CC_ALPHA)) begin
            state_n = ERROR;
          end else if (state == NUM && cls == CC_DIGIT) begin
            if (num_next > 20'h0ffff) state_n = ERROR;
            else                       acc_n   = num_next[15:0];
          end else if (cls == CC_DIGIT || cls == CC_ALPHA) begin
            acc_n = sym_step(acc, bus.in_char[7:0]);
          end else begin
            // Delimiter: emit the accumulated token; PUNCT/EOF waits in the pending slot
            emit        = 1'b1;
            emit_type   = (state == NUM) ? TOK_NUM : TOK_SYM;
            emit_value  = acc;
            acc_n       = '0;
            pend_load   = (cls != CC_WS);
            pend_type_n = (cls == CC_EOF) ? TOK_EOF : punct_tok;
            state_n     = (cls == CC_EOF) ? DONE : SKIP;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_valid  <= 1'b0;
      tok_type   <= TOK_NONE;
      tok_value  <= '0;
      pend_valid <= 1'b0;
      pend_type  <= TOK_NONE;
    end else if (state_n == ERROR) begin
      tok_valid  <= 1'b0;
      tok_type   <= TOK_NONE;
      tok_value  <= '0;
      pend_valid <= 1'b0;
      pend_type  <= TOK_NONE;
    end else if (emit) begin
      tok_valid  <= 1'b1;
      tok_type   <= emit_type;
      tok_value  <= emit_value;
      pend_valid <= pend_load;
      pend_type  <= pend_type_n;
    end else if (pend_valid && out_free) begin
      tok_valid  <= 1'b1;
      tok_type   <= pend_type;
      tok_value  <= '0;
      pend_valid <= 1'b0;
      pend_type  <= TOK_NONE;
    end else if (tok_valid && bus.tok_ready) begin
      tok_valid <= 1'b0;
      tok_type  <= TOK_NONE;
      tok_value <= '0;
    end
  end

endmodule
